// File: rtl/rv_ctl_pkg.sv
// Shared encodings for the multicycle RISC-V control FSM: states, opcode/funct3
// match values and datapath mux select codes.
package rv_ctl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_LSW_ADDR,
    ST_LW_MEM,
    ST_LW_WB,
    ST_SW_MEM,
    ST_R_ALU,
    ST_I_ALU,
    ST_ALU_WB,
    ST_BR_EXEC,
    ST_JAL_EXEC,
    ST_JALR_EXEC,
    ST_TRAP
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SRX  = 3'b101;

  localparam logic       PC_INC = 1'b0;
  localparam logic       PC_ALU = 1'b1;

  localparam logic [1:0] WB_PC     = 2'd0;
  localparam logic [1:0] WB_ALUOUT = 2'd1;
  localparam logic [1:0] WB_MDR    = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic       ALUA_REG = 1'b0;
  localparam logic       ALUA_PCC = 1'b1;
  localparam logic       ALUB_REG = 1'b0;
  localparam logic       ALUB_IMM = 1'b1;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;

  function automatic logic is_mem_state(input state_e s);
    return (s == ST_FETCH) || (s == ST_LW_MEM) || (s == ST_SW_MEM);
  endfunction

endpackage

// File: rtl/rv_mem_wait.sv
// Memory wait counter: counts stalled request cycles and flags a timeout on the
// cycle the count would reach MEM_TIMEOUT without mem_ready.
module rv_mem_wait #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic timeout_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && !ready_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // ready in the final allowed cycle completes the access rather than faulting
  assign timeout_o = busy_i && !ready_i && (cnt_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/rv_ctl_mw.sv
// Multicycle RISC-V control FSM with variable-latency memory handshake and fault trap.
// Optional perf counters (cyc_cnt/ret_cnt) are built only when RV_CTL_PERF_EN is defined.
module rv_ctl_mw
  import rv_ctl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ALUSEL_W    = 4,
  parameter int unsigned IMMSEL_W    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         instr,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                memrw,
  output logic                pcsourse,
  output logic                pcwrite,
  output logic                pccen,
  output logic                irwrite,
  output logic                regwen,
  output logic                mdrwrite,
  output logic [1:0]          wbsel,
  output logic [IMMSEL_W-1:0] immsel,
  output logic                asel,
  output logic                bsel,
  output logic [ALUSEL_W-1:0] alusel,
  output logic                retire,
  output logic                fault
`ifdef RV_CTL_PERF_EN
  ,
  output logic [31:0]         cyc_cnt,
  output logic [31:0]         ret_cnt
`endif
);

  state_e     state_q, state_d;
  logic       fault_q, fault_d;
  logic       timeout;
  logic [6:0] opcode;
  logic [2:0] funct3;

  logic       mem_req_c, memrw_c, pcsrc_c, pcwrite_c, pccen_c, irwrite_c;
  logic       regwen_c, mdrwrite_c, asel_c, bsel_c, retire_c;
  logic [1:0] wbsel_c;
  logic [2:0] immsel_c;
  logic [3:0] alusel_c;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

  always_comb begin
    state_d    = state_q;
    mem_req_c  = 1'b0;
    memrw_c    = 1'b0;
    pcsrc_c    = PC_INC;
    pcwrite_c  = 1'b0;
    pccen_c    = 1'b0;
    irwrite_c  = 1'b0;
    regwen_c   = 1'b0;
    mdrwrite_c = 1'b0;
    wbsel_c    = WB_ALUOUT;
    immsel_c   = IMM_I;
    asel_c     = ALUA_REG;
    bsel_c     = ALUB_REG;
    alusel_c   = ALU_ADD;
    retire_c   = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          irwrite_c = 1'b1;
          pcwrite_c = 1'b1;
          pccen_c   = 1'b1;
          state_d   = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        asel_c   = ALUA_PCC;
        bsel_c   = ALUB_IMM;
        immsel_c = IMM_B;
        state_d  = ST_TRAP;
        case (opcode)
          OPC_LOAD:   if (funct3 == F3_LW) state_d = ST_LSW_ADDR;
          OPC_STORE:  if (funct3 == F3_SW) state_d = ST_LSW_ADDR;
          OPC_R:      state_d = ST_R_ALU;
          OPC_OPIMM:  state_d = ST_I_ALU;
          OPC_BRANCH: if (funct3 == F3_BEQ || funct3 == F3_BNE) state_d = ST_BR_EXEC;
          OPC_JAL:    state_d = ST_JAL_EXEC;
          OPC_JALR:   if (funct3 == F3_JALR) state_d = ST_JALR_EXEC;
          default:    ;
        endcase
      end
      ST_LSW_ADDR: begin
        bsel_c   = ALUB_IMM;
        immsel_c = (opcode == OPC_STORE) ? IMM_S : IMM_I;
        state_d  = (opcode == OPC_STORE) ? ST_SW_MEM : ST_LW_MEM;
      end
      ST_LW_MEM: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          mdrwrite_c = 1'b1;
          state_d    = ST_LW_WB;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_LW_WB: begin
        wbsel_c  = WB_MDR;
        regwen_c = 1'b1;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_SW_MEM: begin
        mem_req_c = 1'b1;
        memrw_c   = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = ST_FETCH;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_R_ALU: begin
        alusel_c = {funct3, instr[30]};
        state_d  = ST_ALU_WB;
      end
      ST_I_ALU: begin
        bsel_c   = ALUB_IMM;
        alusel_c = {funct3, (funct3 == F3_SRX) ? instr[30] : 1'b0};
        state_d  = ST_ALU_WB;
      end
      ST_ALU_WB: begin
        regwen_c = 1'b1;
        retire_c = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_BR_EXEC: begin
        alusel_c  = ALU_SUB;
        pcsrc_c   = PC_ALU;
        pcwrite_c = zero ^ funct3[0];
        retire_c  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JAL_EXEC: begin
        asel_c    = ALUA_PCC;
        bsel_c    = ALUB_IMM;
        immsel_c  = IMM_J;
        pcsrc_c   = PC_ALU;
        pcwrite_c = 1'b1;
        regwen_c  = 1'b1;
        wbsel_c   = WB_PC;
        retire_c  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JALR_EXEC: begin
        bsel_c    = ALUB_IMM;
        pcsrc_c   = PC_ALU;
        pcwrite_c = 1'b1;
        regwen_c  = 1'b1;
        wbsel_c   = WB_PC;
        retire_c  = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase
  end

  assign fault_d = fault_q | (state_d == ST_TRAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  rv_mem_wait #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (is_mem_state(state_d) && (state_d != state_q)),
    .busy_i   (mem_req_c),
    .ready_i  (mem_ready),
    .timeout_o(timeout)
  );

  // Enables are gated by rst_n so nothing is asserted while reset is held.
  assign mem_req  = mem_req_c & rst_n;
  assign memrw    = memrw_c & rst_n;
  assign pcwrite  = pcwrite_c & rst_n;
  assign pccen    = pccen_c & rst_n;
  assign irwrite  = irwrite_c & rst_n;
  assign regwen   = regwen_c & rst_n;
  assign mdrwrite = mdrwrite_c & rst_n;
  assign retire   = retire_c & rst_n;
  assign pcsourse = pcsrc_c;
  assign wbsel    = wbsel_c;
  assign immsel   = IMMSEL_W'(immsel_c);
  assign asel     = asel_c;
  assign bsel     = bsel_c;
  assign alusel   = ALUSEL_W'(alusel_c);
  assign fault    = fault_q;

`ifdef RV_CTL_PERF_EN
  logic [31:0] cyc_q, cyc_d, ret_q, ret_d;

  assign cyc_d = (state_q != ST_TRAP) ? cyc_q + 32'd1 : cyc_q;
  assign ret_d = retire_c ? ret_q + 32'd1 : ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end

  assign cyc_cnt = cyc_q;
  assign ret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_rv_ctl_mw.sv
// Directed bench for rv_ctl_mw: per-cycle control vector checks with hand-derived
// expectations; perf counter checks when RV_CTL_PERF_EN is defined.
module tb_rv_ctl_mw;
  import rv_ctl_pkg::*;

  typedef struct packed {
    logic       mem_req, memrw, pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
    logic [1:0] wbsel;
    logic [2:0] immsel;
    logic       asel, bsel;
    logic [3:0] alusel;
    logic       retire, fault;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        zero, mem_ready;
  logic        mem_req, memrw, pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite;
  logic [1:0]  wbsel;
  logic [2:0]  immsel;
  logic        asel, bsel;
  logic [3:0]  alusel;
  logic        retire, fault;
`ifdef RV_CTL_PERF_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  int unsigned nassert = 0;
  int unsigned nfail   = 0;
  ctl_t obs;
  ctl_t IDLE, FW, FR, DEC, TRAPV, ALUWB, tmp;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_LW   = 32'h0080A283;
  localparam logic [31:0] I_SW   = 32'h0020A223;
  localparam logic [31:0] I_BNE  = 32'h00209463;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_SRAI = 32'h4020D193;
  localparam logic [31:0] I_ADDI = 32'h40008093;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_JALR = 32'h000280E7;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  always #5 clk = ~clk;

  rv_ctl_mw #(
    .MEM_TIMEOUT(4),
    .ALUSEL_W   (4),
    .IMMSEL_W   (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr    (instr),
    .zero     (zero),
    .mem_ready(mem_ready),
    .mem_req  (mem_req),
    .memrw    (memrw),
    .pcsourse (pcsourse),
    .pcwrite  (pcwrite),
    .pccen    (pccen),
    .irwrite  (irwrite),
    .regwen   (regwen),
    .mdrwrite (mdrwrite),
    .wbsel    (wbsel),
    .immsel   (immsel),
    .asel     (asel),
    .bsel     (bsel),
    .alusel   (alusel),
    .retire   (retire),
    .fault    (fault)
`ifdef RV_CTL_PERF_EN
    ,
    .cyc_cnt  (cyc_cnt),
    .ret_cnt  (ret_cnt)
`endif
  );

  assign obs = {mem_req, memrw, pcsourse, pcwrite, pccen, irwrite, regwen, mdrwrite,
                wbsel, immsel, asel, bsel, alusel, retire, fault};

  function automatic ctl_t x(input logic mr, rw, ps, pw, pc, ir, rg, md,
                             input logic [1:0] wb, input logic [2:0] im,
                             input logic a, b, input logic [3:0] al, input logic rt, ft);
    return {mr, rw, ps, pw, pc, ir, rg, md, wb, im, a, b, al, rt, ft};
  endfunction

  task automatic chk(input string tag, input ctl_t exp);
    #1;
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input ctl_t exp);
    chk(tag, exp);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk32(input string tag, input logic [31:0] o, input logic [31:0] e);
    nassert++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  initial begin
    rst_n = 1'b0; instr = '0; zero = 1'b0; mem_ready = 1'b0;
    IDLE  = x(0,0,PC_INC,0,0,0,0,0, WB_ALUOUT, IMM_I, ALUA_REG, ALUB_REG, ALU_ADD, 0, 0);
    FW    = IDLE; FW.mem_req = 1'b1;
    FR    = FW;   FR.pcwrite = 1'b1; FR.pccen = 1'b1; FR.irwrite = 1'b1;
    DEC   = x(0,0,PC_INC,0,0,0,0,0, WB_ALUOUT, IMM_B, ALUA_PCC, ALUB_IMM, ALU_ADD, 0, 0);
    TRAPV = IDLE; TRAPV.fault = 1'b1;
    ALUWB = IDLE; ALUWB.regwen = 1'b1; ALUWB.retire = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset", IDLE);
    rst_n = 1'b1; mem_ready = 1'b1; instr = I_ADD;

    // ADD, zero-wait
    step("add_fetch", FR); step("add_decode", DEC);
    step("add_ralu", IDLE); step("add_wb", ALUWB);

    // LW with 3 wait cycles in both FETCH and LW_MEM
    instr = I_LW; mem_ready = 1'b0;
    step("lw_fwait1", FW); step("lw_fwait2", FW); step("lw_fwait3", FW);
    mem_ready = 1'b1;
    step("lw_fetch", FR); step("lw_decode", DEC);
    tmp = IDLE; tmp.bsel = ALUB_IMM;
    step("lw_addr", tmp);
    mem_ready = 1'b0;
    step("lw_mwait1", FW); step("lw_mwait2", FW); step("lw_mwait3", FW);
    mem_ready = 1'b1;
    tmp = FW; tmp.mdrwrite = 1'b1;
    step("lw_mem", tmp);
    tmp = IDLE; tmp.wbsel = WB_MDR; tmp.regwen = 1'b1; tmp.retire = 1'b1;
    step("lw_wb", tmp);

    // SW with one wait cycle in SW_MEM
    instr = I_SW;
    step("sw_fetch", FR); step("sw_decode", DEC);
    tmp = IDLE; tmp.bsel = ALUB_IMM; tmp.immsel = IMM_S;
    step("sw_addr", tmp);
    mem_ready = 1'b0;
    tmp = FW; tmp.memrw = 1'b1;
    step("sw_wait", tmp);
    mem_ready = 1'b1; tmp.retire = 1'b1;
    step("sw_mem", tmp);

    // Branches
    tmp = x(0,0,PC_ALU,0,0,0,0,0, WB_ALUOUT, IMM_I, ALUA_REG, ALUB_REG, ALU_SUB, 1, 0);
    instr = I_BNE; zero = 1'b1;
    step("bne_z1_fetch", FR); step("bne_z1_decode", DEC); step("bne_z1_exec", tmp);
    zero = 1'b0; tmp.pcwrite = 1'b1;
    step("bne_z0_fetch", FR); step("bne_z0_decode", DEC); step("bne_z0_exec", tmp);
    instr = I_BEQ; zero = 1'b1;
    step("beq_z1_fetch", FR); step("beq_z1_decode", DEC); step("beq_z1_exec", tmp);
    zero = 1'b0;

    // SUB, SRAI, ADDI with instr[30] set
    instr = I_SUB;
    step("sub_fetch", FR); step("sub_decode", DEC);
    tmp = IDLE; tmp.alusel = ALU_SUB;
    step("sub_ralu", tmp); step("sub_wb", ALUWB);
    instr = I_SRAI;
    step("srai_fetch", FR); step("srai_decode", DEC);
    tmp = IDLE; tmp.bsel = ALUB_IMM; tmp.alusel = 4'b1011;
    step("srai_ialu", tmp); step("srai_wb", ALUWB);
    instr = I_ADDI;
    step("addi_fetch", FR); step("addi_decode", DEC);
    tmp = IDLE; tmp.bsel = ALUB_IMM; tmp.alusel = ALU_ADD;
    step("addi_ialu", tmp); step("addi_wb", ALUWB);

    // Jumps
    instr = I_JAL;
    step("jal_fetch", FR); step("jal_decode", DEC);
    step("jal_exec", x(0,0,PC_ALU,1,0,0,1,0, WB_PC, IMM_J, ALUA_PCC, ALUB_IMM, ALU_ADD, 1, 0));
    instr = I_JALR;
    step("jalr_fetch", FR); step("jalr_decode", DEC);
    step("jalr_exec", x(0,0,PC_ALU,1,0,0,1,0, WB_PC, IMM_I, ALUA_REG, ALUB_IMM, ALU_ADD, 1, 0));

    // Memory timeout (MEM_TIMEOUT=4) in FETCH
    mem_ready = 1'b0;
    step("to_wait1", FW); step("to_wait2", FW); step("to_wait3", FW); step("to_wait4", FW);
    step("to_trap", TRAPV);
    mem_ready = 1'b1;
    step("to_trap_hold1", TRAPV); step("to_trap_hold2", TRAPV);

    rst_n = 1'b0;
    chk("to_reset", IDLE);
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0;
    step("rst_fetch_wait", FW);
    rst_n = 1'b0;
    chk("async_reset_midaccess", IDLE);
    @(negedge clk);
    chk("async_reset_held", IDLE);

    // Illegal opcode
    rst_n = 1'b1; mem_ready = 1'b1; instr = I_BAD;
    step("ill_fetch", FR); step("ill_decode", DEC);
    step("ill_trap1", TRAPV); step("ill_trap2", TRAPV);
    rst_n = 1'b0;
    chk("ill_reset", IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    step("ill_after_reset", FR);

`ifdef RV_CTL_PERF_EN
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk32("perf_cyc_reset", cyc_cnt, 32'd0);
    chk32("perf_ret_reset", ret_cnt, 32'd0);
    rst_n = 1'b1; instr = I_ADD; mem_ready = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    #1;
    chk32("perf_ret_cnt", ret_cnt, 32'd10);
    chk32("perf_cyc_cnt", cyc_cnt, 32'd40);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
